// File: rtl/modulator_scheduler.sv
// Round-robin scheduler for two encoded-message sources: hands one message at a time
// to a modulator, then streams the four returned symbols out over a valid/ready port.
module modulator_scheduler #(
    parameter int DATA_W      = 32,
    parameter int SYM_W       = DATA_W / 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        src_valid,
    input  logic [DATA_W-1:0] src_data0,
    input  logic [DATA_W-1:0] src_data1,
    output logic [1:0]        src_ready,
    output logic              mod_en,
    output logic              mod_req,
    output logic [DATA_W-1:0] mod_data,
    input  logic              mod_ack,
    input  logic [DATA_W-1:0] mod_sym,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic [SYM_W-1:0]  sym_data,
    output logic              sym_src,
    output logic              sym_last,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              pref_q, pref_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] mod_data_q, mod_data_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [1:0]        idx_q, idx_d;
    logic [SYM_W-1:0]  sym_buf_q [4];
    logic [SYM_W-1:0]  sym_buf_d [4];
    logic              err_q, err_d;
    logic              take_s;
    logic              grant_s;

    // Arbitration: pref_q names the source that wins a tie (the one not served last).
    always_comb begin
        take_s  = (state_q == S_IDLE) && (src_valid != 2'b00) && !rst;
        grant_s = 1'b0;
        if (src_valid == 2'b11) begin
            grant_s = pref_q;
        end else if (src_valid == 2'b10) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic; a late ack in the final allowed cycle beats the timeout.
    always_comb begin
        state_d    = state_q;
        pref_d     = pref_q;
        grant_d    = grant_q;
        mod_data_d = mod_data_q;
        wait_d     = wait_q;
        idx_d      = idx_q;
        sym_buf_d  = sym_buf_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (take_s) begin
                    state_d    = S_REQ;
                    grant_d    = grant_s;
                    pref_d     = ~grant_s;
                    mod_data_d = grant_s ? src_data1 : src_data0;
                    wait_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mod_ack) begin
                    for (int k = 0; k < 4; k++) begin
                        sym_buf_d[k] = mod_sym[k*SYM_W +: SYM_W];
                    end
                    idx_d   = 2'd0;
                    state_d = S_STREAM;
                end else if ((wait_q + CNT_ONE) == TIMEOUT_V) begin
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + CNT_ONE;
                end
            end
            S_STREAM: begin
                if (sym_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pref_q     <= 1'b0;
            grant_q    <= 1'b0;
            mod_data_q <= '0;
            wait_q     <= '0;
            idx_q      <= 2'd0;
            err_q      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                sym_buf_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pref_q     <= pref_d;
            grant_q    <= grant_d;
            mod_data_q <= mod_data_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            sym_buf_q  <= sym_buf_d;
        end
    end

    // Output decode; symbol fields read zero whenever nothing is being streamed.
    always_comb begin
        src_ready   = 2'b00;
        sym_data    = '0;
        sym_src     = 1'b0;
        if (take_s) begin
            src_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            src_ready = 2'b00;
        end
        if (state_q == S_STREAM) begin
            sym_data = sym_buf_q[idx_q];
            sym_src  = grant_q;
        end else begin
            sym_data = '0;
            sym_src  = 1'b0;
        end
        mod_en      = (state_q == S_REQ);
        mod_req     = (state_q == S_REQ);
        sym_valid   = (state_q == S_STREAM);
        sym_last    = (state_q == S_STREAM) && (idx_q == 2'd3);
        busy        = (state_q != S_IDLE);
        mod_data    = mod_data_q;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_modulator_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and a
// randomized run against a queue-based transaction model of the scheduler.
module tb_modulator_scheduler;

    localparam int DATA_W      = 32;
    localparam int SYM_W       = 8;
    localparam int ACK_TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        src_valid;
    logic [DATA_W-1:0] src_data0, src_data1;
    logic [1:0]        src_ready;
    logic              mod_en, mod_req, mod_ack;
    logic [DATA_W-1:0] mod_data, mod_sym;
    logic              sym_valid, sym_ready, sym_src, sym_last, busy, timeout_err;
    logic [SYM_W-1:0]  sym_data;

    modulator_scheduler #(.DATA_W(DATA_W), .SYM_W(SYM_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_data0(src_data0),
        .src_data1(src_data1), .src_ready(src_ready), .mod_en(mod_en), .mod_req(mod_req),
        .mod_data(mod_data), .mod_ack(mod_ack), .mod_sym(mod_sym), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .sym_data(sym_data), .sym_src(sym_src), .sym_last(sym_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Modulator model state: acks after ack_delay REQ cycles, symbols = mod_data ^ sym_key.
    int                req_cnt   = 0;
    int                ack_delay = 0;
    logic              noise_en  = 1'b0;
    logic [DATA_W-1:0] sym_key   = '0;
    logic              req_seen;

    typedef struct {
        logic [1:0] v;
        logic       rdy;
        logic [1:0] e_ready;
        logic       e_busy;
        logic       e_req;
        logic       e_svalid;
        logic [7:0] e_data;
        logic       e_src;
        logic       e_last;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy);
        src_valid = v;
        sym_ready = rdy;
        if (mod_req) begin
            mod_ack = (req_cnt == ack_delay);
        end else begin
            mod_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mod_sym = mod_data ^ sym_key;
        #1;
    endtask

    task automatic tick();
        req_seen = mod_req;
        @(posedge clk);
        req_cnt = req_seen ? req_cnt + 1 : 0;
        @(negedge clk);
    endtask

    // Randomized-run reference: a message is (REQ cycles left, queue of symbols to emit).
    int               m_req_left;
    logic             m_timed, m_pref, m_src, m_err, m_idle, g;
    logic [SYM_W-1:0] expq [$];
    logic [1:0]       rv, exp_ready;
    logic             rrdy;
    logic [31:0]      word;
    int               dly;

    initial begin
        tbl[0]  = '{2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'hDD, 1'b0, 1'b1};
        tbl[6]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[10] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[11] = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[12] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[13] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[14] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1};
        tbl[15] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1};
        tbl[16] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; src_valid = 2'b00; sym_ready = 1'b0; mod_ack = 1'b0;
        src_data0 = 32'hDDCCBBAA; src_data1 = 32'h44332211; mod_sym = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        drive(2'b00, 1'b0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_svalid", 32'(sym_valid), 32'd0);
        chk("rst_modreq", 32'(mod_req), 32'd0);
        chk("rst_moden", 32'(mod_en), 32'd0);
        chk("rst_moddata", mod_data, 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_sdata", 32'(sym_data), 32'd0);
        tick();

        // Directed table: single message from source 0, then stalled stream from source 1
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].rdy);
            chk($sformatf("tbl%0d_ready", i), 32'(src_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_req", i), 32'(mod_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_en", i), 32'(mod_en), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_svalid", i), 32'(sym_valid), 32'(tbl[i].e_svalid));
            chk($sformatf("tbl%0d_sdata", i), 32'(sym_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_src", i), 32'(sym_src), 32'(tbl[i].e_src));
            chk($sformatf("tbl%0d_last", i), 32'(sym_last), 32'(tbl[i].e_last));
            tick();
        end

        // Both sources valid: grants alternate 0,1,0,1 on a 6-cycle period
        for (int m = 0; m < 4; m++) begin
            drive(2'b11, 1'b1);
            chk($sformatf("rr%0d_grant", m), 32'(src_ready), (m % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            drive(2'b11, 1'b1);
            chk($sformatf("rr%0d_req", m), 32'(mod_req), 32'd1);
            tick();
            for (int s = 0; s < 4; s++) begin
                drive(2'b11, 1'b1);
                chk($sformatf("rr%0d_s%0d_valid", m, s), 32'(sym_valid), 32'd1);
                chk($sformatf("rr%0d_s%0d_src", m, s), 32'(sym_src), 32'(m % 2));
                tick();
            end
        end

        // Ack never arrives: 15 REQ cycles, then sticky error and the other source wins
        ack_delay = 99;
        drive(2'b11, 1'b1);
        chk("to_grant", 32'(src_ready), 32'd1);
        tick();
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            drive(2'b00, 1'b1);
            chk($sformatf("to_req%0d", i), 32'(mod_req), 32'd1);
            chk($sformatf("to_err%0d", i), 32'(timeout_err), 32'd0);
            tick();
        end
        ack_delay = 0;
        drive(2'b11, 1'b1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_nosym", 32'(sym_valid), 32'd0);
        chk("to_next_grant", 32'(src_ready), 32'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b1);
            chk($sformatf("to_after%0d_valid", i), 32'(sym_valid), (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("to_after%0d_src", i), 32'(sym_src), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        drive(2'b00, 1'b1);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        tick();

        // Reset in mid-stream at symbol index 2
        drive(2'b01, 1'b1);
        chk("mr_grant", 32'(src_ready), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1'b1);
            tick();
        end
        drive(2'b00, 1'b1);
        chk("mr_idx2", 32'(sym_data), 32'hCC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'b11, 1'b1);
        chk("mr_svalid", 32'(sym_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_err", 32'(timeout_err), 32'd0);
        chk("mr_grant0", 32'(src_ready), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b1);
            tick();
        end

        // Randomized run against the transaction model
        rst = 1'b1;
        drive(2'b00, 1'b0);
        tick();
        rst = 1'b0;
        noise_en = 1'b1;
        sym_key = 32'h5A5AC3C3;
        m_req_left = 0; m_timed = 1'b0; m_pref = 1'b0; m_src = 1'b0; m_err = 1'b0;
        expq.delete();
        for (int c = 0; c < 2000; c++) begin
            rv = 2'($urandom_range(0, 3));
            rrdy = ($urandom_range(0, 3) != 0);
            src_data0 = $urandom;
            src_data1 = $urandom;
            drive(rv, rrdy);
            m_idle = (m_req_left == 0) && (expq.size() == 0);
            g = (rv == 2'b11) ? m_pref : rv[1];
            exp_ready = (m_idle && rv != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_ready", 32'(src_ready), 32'(exp_ready));
            chk("rnd_busy", 32'(busy), 32'(!m_idle));
            chk("rnd_req", 32'(mod_req), 32'(m_req_left > 0));
            chk("rnd_err", 32'(timeout_err), 32'(m_err));
            chk("rnd_svalid", 32'(sym_valid), 32'(m_req_left == 0 && expq.size() > 0));
            if (m_req_left == 0 && expq.size() > 0) begin
                chk("rnd_sdata", 32'(sym_data), 32'(expq[0]));
                chk("rnd_src", 32'(sym_src), 32'(m_src));
                chk("rnd_last", 32'(sym_last), 32'(expq.size() == 1));
            end
            if (m_idle && rv != 2'b00) begin
                m_pref = ~g;
                m_src = g;
                dly = $urandom_range(0, 17);
                ack_delay = dly;
                if (dly < ACK_TIMEOUT) begin
                    m_req_left = dly + 1;
                    m_timed = 1'b0;
                    word = (g ? src_data1 : src_data0) ^ sym_key;
                    for (int k = 0; k < 4; k++) begin
                        expq.push_back(word[k*SYM_W +: SYM_W]);
                    end
                end else begin
                    m_req_left = ACK_TIMEOUT;
                    m_timed = 1'b1;
                end
            end else if (m_req_left > 0) begin
                m_req_left--;
                if (m_req_left == 0 && m_timed) begin
                    m_err = 1'b1;
                end
            end else if (expq.size() > 0 && rrdy) begin
                void'(expq.pop_front());
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
